// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline stall/flush sequencer and the mult/div
// datapath: next-PC source encodings, the exception handler address, default
// mult/div latencies and the bundle of per-stage control strobes.
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

  // Next-PC source selection.
  typedef enum logic [1:0] {
    PC_SEL_SEQ     = 2'd0,  // sequential / branch target
    PC_SEL_HANDLER = 2'd1,  // exception / interrupt handler
    PC_SEL_EPC     = 2'd2   // return from exception
  } pc_sel_e;

  localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

  // Busy cycles after a mult/div start; the mult/div datapath uses the same values.
  localparam int MD_MULT_CYCLES = 5;
  localparam int MD_DIV_CYCLES  = 10;
  localparam int MD_CNT_W       = 4;

  // Control strobes produced every cycle by the sequencer.
  typedef struct packed {
    logic    pc_we;
    pc_sel_e pc_sel;
    logic    if_id_we;
    logic    if_id_clr;
    logic    id_ex_clr;
    logic    ex_mem_clr;
    logic    mem_wb_clr;
  } ctrl_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_if
// Request/control bundle between the pipeline stages and pipe_ctrl.
//   Requests (pipeline -> pipe_ctrl): stall_req_D, md_start_E, md_is_div_E,
//     md_use_D, exc_req_M, eret_D
//   Controls (pipe_ctrl -> pipeline): pc_we, pc_sel, if_id_we, if_id_clr,
//     id_ex_clr, ex_mem_clr, mem_wb_clr, md_busy, stall_cnt
// master: the pipeline side; slave: pipe_ctrl.
// -----------------------------------------------------------------------------
interface pipe_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic        stall_req_D;
  logic        md_start_E;
  logic        md_is_div_E;
  logic        md_use_D;
  logic        exc_req_M;
  logic        eret_D;

  logic        pc_we;
  pc_sel_e     pc_sel;
  logic        if_id_we;
  logic        if_id_clr;
  logic        id_ex_clr;
  logic        ex_mem_clr;
  logic        mem_wb_clr;
  logic        md_busy;
  logic [31:0] stall_cnt;

  modport master (
    output stall_req_D, md_start_E, md_is_div_E, md_use_D, exc_req_M, eret_D,
    input  pc_we, pc_sel, if_id_we, if_id_clr, id_ex_clr, ex_mem_clr,
           mem_wb_clr, md_busy, stall_cnt
  );

  modport slave (
    input  stall_req_D, md_start_E, md_is_div_E, md_use_D, exc_req_M, eret_D,
    output pc_we, pc_sel, if_id_we, if_id_clr, id_ex_clr, ex_mem_clr,
           mem_wb_clr, md_busy, stall_cnt
  );

endinterface

// File: rtl/pipe_ctrl_md_busy_counter.sv
// -----------------------------------------------------------------------------
// md_busy_counter
// Countdown tracking how long the multi-cycle mult/div unit stays busy.
//   clk, reset : clock, synchronous active-high reset
//   start      : qualified start (already masked by an exception flush)
//   is_div     : 1 = div/divu latency, 0 = mult/multu latency
//   busy       : counter non-zero or a start this cycle
// A start while busy reloads the full latency rather than adding to it.
// -----------------------------------------------------------------------------
module md_busy_counter
  import pipe_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES,
  parameter int CNT_W       = MD_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: load on start, otherwise decrement and hold at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = is_div ? DIV_LOAD : MULT_LOAD;
    end else if (cnt_q != CNT_ZERO) begin
      cnt_d = cnt_q - CNT_ONE;
    end else begin
      cnt_d = CNT_ZERO;
    end
  end

  // Busy counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= CNT_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The start cycle itself counts as busy, so the unit is busy for N+1 cycles.
  assign busy = (cnt_q != CNT_ZERO) | start;

endmodule

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
// Central stall/flush sequencer for the 5-stage pipeline.
//   clk, reset : clock, synchronous active-high reset
//   bus        : pipe_ctrl_if.slave carrying hazard/exception requests in and
//                PC / pipeline-register strobes, md_busy and the stalled-cycle
//                performance counter out
// Priority (highest first): reset > exception at M > stall > eret at D > normal.
// All strobes are combinational from the current state and requests.
// -----------------------------------------------------------------------------
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES,
  parameter int CNT_W       = MD_CNT_W
) (
  input  logic        clk,
  input  logic        reset,
  pipe_ctrl_if.slave  bus
);

  logic        md_start_s;
  logic        md_busy_raw_s;
  logic        md_stall_s;
  logic        stall_s;
  ctrl_t       ctrl_s;
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;

  // An exception flushes E, so its mult/div instruction never starts.
  assign md_start_s = bus.md_start_E & ~bus.exc_req_M;

  md_busy_counter #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md_busy_counter (
    .clk    (clk),
    .reset  (reset),
    .start  (md_start_s),
    .is_div (bus.md_is_div_E),
    .busy   (md_busy_raw_s)
  );

  assign md_stall_s = bus.md_use_D & md_busy_raw_s;
  assign stall_s    = (bus.stall_req_D | md_stall_s) & ~bus.exc_req_M;

  // Priority resolution of the pipeline strobes; defaults describe normal flow.
  always_comb begin
    ctrl_s.pc_we      = 1'b1;
    ctrl_s.pc_sel     = PC_SEL_SEQ;
    ctrl_s.if_id_we   = 1'b1;
    ctrl_s.if_id_clr  = 1'b0;
    ctrl_s.id_ex_clr  = 1'b0;
    ctrl_s.ex_mem_clr = 1'b0;
    ctrl_s.mem_wb_clr = 1'b0;
    if (reset) begin
      ctrl_s.pc_we      = 1'b0;
      ctrl_s.if_id_we   = 1'b0;
      ctrl_s.if_id_clr  = 1'b1;
      ctrl_s.id_ex_clr  = 1'b1;
      ctrl_s.ex_mem_clr = 1'b1;
      ctrl_s.mem_wb_clr = 1'b1;
    end else if (bus.exc_req_M) begin
      // Flush F, D and E; a pending eret in D is squashed by the IF/ID clear.
      ctrl_s.pc_sel     = PC_SEL_HANDLER;
      ctrl_s.if_id_clr  = 1'b1;
      ctrl_s.id_ex_clr  = 1'b1;
      ctrl_s.ex_mem_clr = 1'b1;
    end else if (stall_s) begin
      // Hold PC and D, inject a bubble into E; an eret in D simply waits.
      ctrl_s.pc_we      = 1'b0;
      ctrl_s.if_id_we   = 1'b0;
      ctrl_s.id_ex_clr  = 1'b1;
    end else if (bus.eret_D) begin
      // No delay slot: the instruction fetched behind eret is killed.
      ctrl_s.pc_sel     = PC_SEL_EPC;
      ctrl_s.if_id_clr  = 1'b1;
    end else begin
      ctrl_s.pc_sel     = PC_SEL_SEQ;
    end
  end

  // Stalled-cycle count, wrapping modulo 2^32.
  always_comb begin
    if (stall_s) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Performance counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.pc_we      = ctrl_s.pc_we;
  assign bus.pc_sel     = ctrl_s.pc_sel;
  assign bus.if_id_we   = ctrl_s.if_id_we;
  assign bus.if_id_clr  = ctrl_s.if_id_clr;
  assign bus.id_ex_clr  = ctrl_s.id_ex_clr;
  assign bus.ex_mem_clr = ctrl_s.ex_mem_clr;
  assign bus.mem_wb_clr = ctrl_s.mem_wb_clr;
  assign bus.md_busy    = md_busy_raw_s & ~reset;
  assign bus.stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl
// Directed scenarios plus randomized traffic against a behavioural model that
// tracks the mult/div unit as "busy until cycle X" and counts stalls directly.
// Control bundle layout used for comparisons:
//   {pc_we, pc_sel[1:0], if_id_we, if_id_clr, id_ex_clr, ex_mem_clr,
//    mem_wb_clr, md_busy}
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipe_ctrl_if bus ();

  pipe_ctrl #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10),
    .CNT_W       (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          busy_end = -1;   // last cycle in which the mult/div unit is busy
  logic [31:0] m_stall_cnt = 32'd0;
  logic [8:0]  exp_ctrl;
  logic [31:0] exp_cnt;

  localparam logic [8:0] P_RESET  = 9'b0_00_0_1111_0;
  localparam logic [8:0] P_NORMAL = 9'b1_00_1_0000_0;
  localparam logic [8:0] P_STALL  = 9'b0_00_0_0100_1;

  function automatic logic [8:0] obs_ctrl();
    return {bus.pc_we, bus.pc_sel, bus.if_id_we, bus.if_id_clr, bus.id_ex_clr,
            bus.ex_mem_clr, bus.mem_wb_clr, bus.md_busy};
  endfunction

  // Apply one cycle of inputs, compute the model's expectations for it, advance
  // the model to the next cycle, and wait to the middle of the cycle.
  task automatic drive(input logic rst, input logic sreq, input logic mds,
                       input logic mdd, input logic mduse, input logic exc,
                       input logic eret);
    logic busy;
    logic stall;
    reset           = rst;
    bus.stall_req_D = sreq;
    bus.md_start_E  = mds;
    bus.md_is_div_E = mdd;
    bus.md_use_D    = mduse;
    bus.exc_req_M   = exc;
    bus.eret_D      = eret;
    busy  = !rst && ((busy_end >= cyc) || (mds && !exc));
    stall = !exc && (sreq || (mduse && busy));
    if (rst)        exp_ctrl = P_RESET;
    else if (exc)   exp_ctrl = {1'b1, 2'd1, 1'b1, 4'b1110, busy};
    else if (stall) exp_ctrl = {1'b0, 2'd0, 1'b0, 4'b0100, busy};
    else if (eret)  exp_ctrl = {1'b1, 2'd2, 1'b1, 4'b1000, busy};
    else            exp_ctrl = {1'b1, 2'd0, 1'b1, 4'b0000, busy};
    exp_cnt = m_stall_cnt;
    if (rst) begin
      busy_end    = -1;
      m_stall_cnt = 32'd0;
    end else begin
      if (stall) m_stall_cnt = m_stall_cnt + 32'd1;
      if (mds && !exc) busy_end = cyc + (mdd ? 10 : 5);
    end
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      checks++;
      if (obs_ctrl() !== P_RESET) begin
        errors++;
        $display("FAIL reset_ctrl cyc=%0d got=%b exp=%b", i, obs_ctrl(), P_RESET);
      end
      if (i == 1) begin
        checks++;
        if (bus.stall_cnt !== 32'd0) begin
          errors++;
          $display("FAIL reset_stall_cnt got=%0d exp=0", bus.stall_cnt);
        end
      end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (obs_ctrl() !== P_NORMAL || bus.stall_cnt !== 32'd0) begin
        errors++;
        $display("FAIL idle_after_reset cyc=%0d got=%b/%0d exp=%b/0", i,
                 obs_ctrl(), bus.stall_cnt, P_NORMAL);
      end
      tick();
    end
  endtask

  task automatic test_mult_stall();
    logic [8:0] e;
    do_reset();
    for (int i = 0; i <= 6; i++) begin
      drive(1'b0, 1'b0, (i == 0), 1'b0, 1'b1, 1'b0, 1'b0);
      e = (i <= 5) ? P_STALL : P_NORMAL;
      checks++;
      if (obs_ctrl() !== e) begin
        errors++;
        $display("FAIL mult_stall cyc=%0d got=%b exp=%b", i, obs_ctrl(), e);
      end
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.stall_cnt !== 32'd6) begin
      errors++;
      $display("FAIL mult_stall_cnt got=%0d exp=6", bus.stall_cnt);
    end
    tick();
  endtask

  task automatic test_div_reload();
    logic [8:0] e;
    do_reset();
    for (int i = 0; i <= 10; i++) begin
      drive(1'b0, 1'b0, (i == 0 || i == 3), (i == 0), 1'b0, 1'b0, 1'b0);
      e = {P_NORMAL[8:1], (i <= 8)};
      checks++;
      if (obs_ctrl() !== e) begin
        errors++;
        $display("FAIL div_reload cyc=%0d got=%b exp=%b", i, obs_ctrl(), e);
      end
      tick();
    end
  endtask

  task automatic test_exc_priority();
    do_reset();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    checks++;
    if (obs_ctrl() !== 9'b1_01_1_1110_0) begin
      errors++;
      $display("FAIL exc_priority got=%b exp=%b", obs_ctrl(), 9'b1_01_1_1110_0);
    end
    tick();
    // md_use_D held: a wrongly loaded counter would show up as a stall here.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs_ctrl() !== P_NORMAL || bus.stall_cnt !== 32'd0) begin
      errors++;
      $display("FAIL exc_no_load got=%b/%0d exp=%b/0", obs_ctrl(), bus.stall_cnt, P_NORMAL);
    end
    tick();
  endtask

  task automatic test_eret_stall();
    logic [8:0] e;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, (i < 2), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      e = (i < 2) ? 9'b0_00_0_0100_0 : 9'b1_10_1_1000_0;
      checks++;
      if (obs_ctrl() !== e) begin
        errors++;
        $display("FAIL eret_stall cyc=%0d got=%b exp=%b", i, obs_ctrl(), e);
      end
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.stall_cnt !== 32'd2) begin
      errors++;
      $display("FAIL eret_stall_cnt got=%0d exp=2", bus.stall_cnt);
    end
    tick();
  endtask

  task automatic test_reset_mid_count();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, (i == 0), 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs_ctrl() !== P_RESET) begin
      errors++;
      $display("FAIL mid_reset_ctrl got=%b exp=%b", obs_ctrl(), P_RESET);
    end
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs_ctrl() !== P_NORMAL || bus.stall_cnt !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset_after got=%b/%0d exp=%b/0", obs_ctrl(), bus.stall_cnt, P_NORMAL);
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 5) == 0), $urandom_range(0, 1) == 1,
            ($urandom_range(0, 1) == 0), ($urandom_range(0, 11) == 0),
            ($urandom_range(0, 7) == 0));
      checks++;
      if (obs_ctrl() !== exp_ctrl) begin
        errors++;
        $display("FAIL random_ctrl cyc=%0d got=%b exp=%b", cyc, obs_ctrl(), exp_ctrl);
      end
      checks++;
      if (bus.stall_cnt !== exp_cnt) begin
        errors++;
        $display("FAIL random_stall_cnt cyc=%0d got=%0d exp=%0d", cyc, bus.stall_cnt, exp_cnt);
      end
      tick();
    end
  endtask

  initial begin
    reset           = 1'b1;
    bus.stall_req_D = 1'b0;
    bus.md_start_E  = 1'b0;
    bus.md_is_div_E = 1'b0;
    bus.md_use_D    = 1'b0;
    bus.exc_req_M   = 1'b0;
    bus.eret_D      = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_mult_stall();
    test_div_reload();
    test_exc_priority();
    test_eret_stall();
    test_reset_mid_count();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Drives the write-enable and clear of the IF/ID register and the clears of ID/EX, EX/MEM and MEM/WB. Also drives PC write-enable and next-PC source selection.
- Tracks the multi-cycle mult/div unit with a busy countdown.
- Arbitrates between data-hazard stalls, mult/div stalls, exception/interrupt entry (signalled from M) and eret (decoded in D).

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu after start
- DIV_CYCLES, 10, busy cycles for div/divu after start
- CNT_W, 4, width of the busy counter; must hold DIV_CYCLES

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- stall_req_D  in  1  data-hazard stall from the forwarding unit (combinational)
- md_start_E  in  1  mult/div instruction issuing in E this cycle
- md_is_div_E  in  1  qualifies md_start_E: 1=div/divu, 0=mult/multu
- md_use_D  in  1  instruction in D is mult/div/mfhi/mflo/mthi/mtlo
- exc_req_M  in  1  exception or interrupt taken at M this cycle
- eret_D  in  1  eret in D
- pc_we  out  1  PC register write-enable
- pc_sel  out  2  next PC source: 0=sequential/branch, 1=handler 0x0000_4180, 2=EPC
- if_id_we  out  1  IF/ID write-enable
- if_id_clr  out  1  IF/ID clear
- id_ex_clr  out  1  ID/EX clear (bubble insertion)
- ex_mem_clr  out  1  EX/MEM clear
- mem_wb_clr  out  1  MEM/WB clear; always 0, reserved
- md_busy  out  1  mult/div unit busy, including the start cycle
- stall_cnt  out  32  performance counter of stalled cycles

Behaviour:
- One clock, clk. Reset is synchronous and active-high on reset.
- Reset values:
  - busy counter = 0, stall_cnt = 0.
  - While reset is high, control outputs take the reset pattern: pc_we=0, if_id_we=0, all clr=1, pc_sel=0, md_busy=0.
- Registered state: busy counter `cnt` (CNT_W bits) and stall_cnt. All control outputs are combinational from current state and inputs, i.e. zero latency.
- md_busy = (cnt != 0) | (md_start_E & ~exc_req_M).
- md_stall = md_use_D & md_busy.
- stall = (stall_req_D | md_stall) & ~exc_req_M.
- Priority, highest first: reset > exc_req_M > stall > eret_D > normal.
  - exc_req_M: pc_we=1, pc_sel=1, if_id_clr=1, id_ex_clr=1, ex_mem_clr=1, if_id_we=1. The E-stage instruction is flushed, so md_start_E is ignored and cnt is not loaded by it. An already-running count keeps decrementing.
  - stall: pc_we=0, if_id_we=0, id_ex_clr=1, pc_sel=0, if_id_clr=0, ex_mem_clr=0. Because the instruction in D is held, eret_D under stall waits.
  - eret_D without stall: pc_we=1, pc_sel=2, if_id_we=1, if_id_clr=1. The instruction fetched after eret is killed; there is no delay slot for eret.
  - normal: pc_we=1, pc_sel=0, if_id_we=1, every clr=0.
- Counter update, per cycle:
  - if md_start_E & ~exc_req_M: cnt <= md_is_div_E ? DIV_CYCLES : MULT_CYCLES. A restart while busy reloads; it does not add.
  - else if cnt != 0: cnt <= cnt-1.
  - cnt saturates at 0; no wrap.
- md_busy timing: after a start at cycle T, md_busy is high in cycles T through T+N, then low at T+N+1, where N = MULT_CYCLES or DIV_CYCLES.
- stall_cnt increments by 1 in each cycle where stall=1 and reset=0. It wraps modulo 2^32.
- Reset asserted mid-count clears cnt next edge. md_start_E in the reset cycle is ignored.
- Simultaneous exc_req_M & eret_D: the exception wins, and eret is flushed by if_id_clr.

Decomposition:
- Shared package/header holds:
  - PC_SEL_* encodings (SEQ=0, HANDLER=1, EPC=2)
  - HANDLER_ADDR = 32'h0000_4180
  - MULT_CYCLES / DIV_CYCLES defaults, so the mult/div datapath uses the same values
- One natural sub-module, md_busy_counter: cnt register, load/decrement, md_busy output. Priority/output logic stays in pipe_ctrl.

Test Plan:
- Reset released, all request inputs 0 -> pc_we=1, if_id_we=1, all clr=0, pc_sel=0, stall_cnt stays 0.
- md_start_E=1, md_is_div_E=0 at cycle 0, md_use_D=1 held -> md_busy=1 cycles 0..5, stall (pc_we=0, id_ex_clr=1) cycles 0..5, released cycle 6, stall_cnt=6.
- md_start_E=1, md_is_div_E=1, reload with mult at cycle 3 -> md_busy low at cycle 9, not 11.
- exc_req_M=1 together with md_start_E=1, stall_req_D=1 and eret_D=1 -> pc_sel=1, pc_we=1, if_id_clr=id_ex_clr=ex_mem_clr=1, cnt stays 0, stall_cnt unchanged.
- eret_D=1 with stall_req_D=1 for 2 cycles, then stall_req_D=0 -> two stall cycles with pc_sel=0, then one cycle pc_sel=2 with if_id_clr=1.
- Reset pulsed at cycle 4 of a div count -> cnt=0, md_busy=0 from the next cycle, stall_cnt=0.
